// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the sequential shift-add multiplier.
//
// Contents:
//   mul_state_e        controller state encoding (IDLE, CALC, DONE), 2 bits
//   MUL_WIDTH_DEFAULT  default operand width
//   MUL_COUNT_W        iteration counter width for the default operand width
//   mul_count_width()  counter width for an arbitrary operand width (min 1)
// -----------------------------------------------------------------------------
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    localparam int MUL_WIDTH_DEFAULT = 4;
    localparam int MUL_COUNT_W       = $clog2(MUL_WIDTH_DEFAULT);

    // $clog2 returns 0 for widths below 2; the counter still needs one bit.
    function automatic int mul_count_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/mul_add_stage.sv
// -----------------------------------------------------------------------------
// mul_add_stage
// Purely combinational WIDTH-bit adder with carry-out. This is the one adder
// the multiply sequencer reuses every iteration; it is kept as its own module
// so the ALU add path can share the same instance.
//
// Ports:
//   operand_a  [WIDTH-1:0]  in   first addend
//   operand_b  [WIDTH-1:0]  in   second addend
//   sum        [WIDTH-1:0]  out  low WIDTH bits of operand_a + operand_b
//   carry_out               out  carry out of the MSB
// -----------------------------------------------------------------------------
module mul_add_stage #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    // Extending both operands by one bit keeps the carry as the sum MSB.
    assign {carry_out, sum} = {1'b0, operand_a} + {1'b0, operand_b};

endmodule

// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
// Sequential shift-add unsigned multiplier controller. One multiplier bit is
// processed per clock through a single shared mul_add_stage. Operands are
// captured on an accepted start, and the 2*WIDTH-bit product is held from the
// DONE cycle until the next accepted start.
//
// Optional build macro:
//   MUL_SEQ_EARLY_EXIT_EN  finish as soon as the remaining multiplier bits are
//                          all zero (b == 0 goes straight from IDLE to DONE).
//                          Products are identical in both builds.
//
// Ports:
//   clk      in   rising-edge system clock
//   rst_n    in   synchronous active-low reset
//   start    in   operation request, sampled only in IDLE
//   a        in   [WIDTH-1:0] multiplicand, unsigned
//   b        in   [WIDTH-1:0] multiplier, unsigned
//   ready    out  high in IDLE (decoded from state)
//   busy     out  high in CALC (decoded from state)
//   done     out  registered one-cycle pulse in DONE
//   product  out  [2*WIDTH-1:0] registered result
// -----------------------------------------------------------------------------
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int              CW         = mul_count_width(WIDTH);
    localparam logic [CW-1:0]   LAST_COUNT = CW'(WIDTH - 1);

    mul_state_e            state;
    logic [WIDTH-1:0]      acc;
    logic [WIDTH-1:0]      mcand;
    logic [WIDTH-1:0]      mplier;
    logic [CW-1:0]         count;

    logic [WIDTH-1:0]      addend;
    logic [WIDTH-1:0]      add_sum;
    logic                  add_carry;
    logic [2*WIDTH-1:0]    shifted;
    logic                  last_iter;
    logic                  finish;
    logic [2*WIDTH-1:0]    final_product;

    // The multiplicand is added only when the current multiplier LSB is set.
    assign addend = mplier[0] ? mcand : '0;

    mul_add_stage #(
        .WIDTH (WIDTH)
    ) u_add_stage (
        .operand_a (acc),
        .operand_b (addend),
        .sum       (add_sum),
        .carry_out (add_carry)
    );

    // {carry, sum, mplier} shifted right by one: the carry lands in the acc
    // MSB and the consumed multiplier LSB drops off the bottom.
    assign shifted   = {add_carry, add_sum, mplier[WIDTH-1:1]};
    assign last_iter = (count == LAST_COUNT);

`ifdef MUL_SEQ_EARLY_EXIT_EN
    logic                  rest_zero;
    logic [CW-1:0]         remaining;

    // Bits 1 .. WIDTH-1-count of mplier are the multiplier bits not yet
    // consumed after this iteration; above them sit already-produced
    // product bits, which must not be tested.
    always_comb begin
        rest_zero = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            if ((i <= (WIDTH - 1 - int'(count))) && mplier[i]) begin
                rest_zero = 1'b0;
            end
        end
    end

    // Skipped iterations would only shift zeros in, so the missing shifts
    // are applied here in one go.
    assign remaining     = LAST_COUNT - count;
    assign final_product = shifted >> remaining;
    assign finish        = last_iter | rest_zero;
`else
    assign final_product = shifted;
    assign finish        = last_iter;
`endif

    assign ready = (state == IDLE);
    assign busy  = (state == CALC);

    // Controller: captures operands, runs one shift-add iteration per clock
    // in CALC, latches the product on the way into DONE and pulses done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
`ifdef MUL_SEQ_EARLY_EXIT_EN
                        if (b == '0) begin
                            product <= '0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state   <= CALC;
                        end
`else
                        state  <= CALC;
`endif
                    end
                end

                CALC: begin
                    acc    <= shifted[2*WIDTH-1:WIDTH];
                    mplier <= shifted[WIDTH-1:0];
                    count  <= count + CW'(1);
                    if (finish) begin
                        product <= final_product;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_sequencer
// Self-checking bench for mul_sequencer (WIDTH = 4). Expected products and
// latencies are pushed to a scoreboard queue when an operation is accepted
// and popped when done is observed. Outputs are sampled on the falling edge.
// Expected latency follows MUL_SEQ_EARLY_EXIT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_mul_sequencer;

    typedef struct {
        logic [7:0] prod;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    exp_t sb[$];

    mul_sequencer #(
        .WIDTH (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    // Cycles from the accepting edge to the cycle in which done is high.
    function automatic int exp_latency(input logic [3:0] bv);
`ifdef MUL_SEQ_EARLY_EXIT_EN
        int h;
        if (bv == 4'd0) return 1;
        h = 0;
        for (int i = 0; i < 4; i++) if (bv[i]) h = i;
        return h + 2;
`else
        return 5;
`endif
    endfunction

    // Runs one operation: waits for ready, requests, pushes the expectation on
    // acceptance, waits for done (bounded) and pops the matching expectation.
    task automatic drive_op(input logic [3:0] av, input logic [3:0] bv,
                            input bit scramble,
                            output logic [7:0] prod, output int lat,
                            output logic done_after,
                            output logic [7:0] e_prod, output int e_lat);
        int   waited;
        exp_t e;
        @(negedge clk);
        waited = 0;
        while (!ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        start = 1'b1;
        a = av;
        b = bv;
        @(negedge clk);
        e.prod = {4'd0, av} * {4'd0, bv};
        e.lat  = exp_latency(bv);
        sb.push_back(e);
        start = 1'b0;
        if (scramble) begin
            a = ~av;
            b = ~bv;
        end
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (waited >= 20) lat = -1;
        prod = product;
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e.prod = 8'hxx;
            e.lat  = -1;
        end
        e_prod = e.prod;
        e_lat  = e.lat;
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset();
        start = 1'b1;
        a = 4'd15;
        b = 4'd15;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_compared++;
        if (ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
        n_compared++;
        if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_compared++;
        if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        n_compared++;
        if (product !== 8'd0) begin n_mismatched++; $display("[TB] FAIL reset_product: got %0d expected 0", product); end
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_max_operands();
        logic [7:0] prod, e_prod;
        int lat, e_lat;
        logic done_after;
        drive_op(4'd15, 4'd15, 1'b0, prod, lat, done_after, e_prod, e_lat);
        n_compared++;
        if (prod !== e_prod) begin n_mismatched++; $display("[TB] FAIL max_product: got %0d expected %0d", prod, e_prod); end
        n_compared++;
        if (lat !== e_lat) begin n_mismatched++; $display("[TB] FAIL max_latency: got %0d expected %0d", lat, e_lat); end
        n_compared++;
        if (done_after !== 1'b0) begin n_mismatched++; $display("[TB] FAIL max_done_width: done still %b after pulse", done_after); end
        n_compared++;
        if (ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL max_ready_return: got %b expected 1", ready); end
    endtask

    task automatic test_product_hold();
        logic [7:0] prod, e_prod;
        int lat, e_lat;
        logic done_after;
        drive_op(4'd6, 4'd7, 1'b0, prod, lat, done_after, e_prod, e_lat);
        n_compared++;
        if (prod !== e_prod) begin n_mismatched++; $display("[TB] FAIL hold_first_product: got %0d expected %0d", prod, e_prod); end
        repeat (3) @(negedge clk);
        n_compared++;
        if (product !== 8'd42) begin n_mismatched++; $display("[TB] FAIL hold_idle_product: got %0d expected 42", product); end
        drive_op(4'd0, 4'd9, 1'b0, prod, lat, done_after, e_prod, e_lat);
        n_compared++;
        if (prod !== e_prod) begin n_mismatched++; $display("[TB] FAIL hold_zero_product: got %0d expected %0d", prod, e_prod); end
        n_compared++;
        if (lat !== e_lat) begin n_mismatched++; $display("[TB] FAIL hold_zero_latency: got %0d expected %0d", lat, e_lat); end
    endtask

    task automatic test_start_held();
        exp_t e;
        int   lat;
        int   waited;
        @(negedge clk);
        waited = 0;
        while (!ready && waited < 20) begin @(negedge clk); waited++; end
        start = 1'b1;
        a = 4'd3;
        b = 4'd5;
        @(negedge clk);
        e.prod = 8'd15;
        e.lat  = exp_latency(4'd5);
        sb.push_back(e);
        a = 4'd15;
        b = 4'd15;
        lat = 1;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        e = sb.pop_front();
        n_compared++;
        if (product !== e.prod) begin n_mismatched++; $display("[TB] FAIL held_first_product: got %0d expected %0d", product, e.prod); end
        n_compared++;
        if (lat !== e.lat) begin n_mismatched++; $display("[TB] FAIL held_first_latency: got %0d expected %0d", lat, e.lat); end
        @(negedge clk);
        n_compared++;
        if (ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL held_ready_after_done: got %b expected 1", ready); end
        e.prod = 8'd225;
        e.lat  = exp_latency(4'd15);
        sb.push_back(e);
        @(negedge clk);
        n_compared++;
        if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL held_second_accept: busy got %b expected 1", busy); end
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        e = sb.pop_front();
        n_compared++;
        if (product !== e.prod) begin n_mismatched++; $display("[TB] FAIL held_second_product: got %0d expected %0d", product, e.prod); end
        n_compared++;
        if (lat !== e.lat) begin n_mismatched++; $display("[TB] FAIL held_second_latency: got %0d expected %0d", lat, e.lat); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_calc();
        logic [7:0] prod, e_prod;
        int lat, e_lat;
        logic done_after;
        logic saw_done;
        int waited;
        @(negedge clk);
        waited = 0;
        while (!ready && waited < 20) begin @(negedge clk); waited++; end
        start = 1'b1;
        a = 4'd5;
        b = 4'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_compared++;
        if (ready !== 1'b1 || busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_state: ready=%b busy=%b expected ready=1 busy=0", ready, busy); end
        n_compared++;
        if (product !== 8'd0) begin n_mismatched++; $display("[TB] FAIL abort_product: got %0d expected 0", product); end
        saw_done = done;
        repeat (8) begin @(negedge clk); saw_done = saw_done | done; end
        n_compared++;
        if (saw_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_no_done: got %b expected 0", saw_done); end
        drive_op(4'd9, 4'd9, 1'b0, prod, lat, done_after, e_prod, e_lat);
        n_compared++;
        if (prod !== e_prod) begin n_mismatched++; $display("[TB] FAIL abort_next_product: got %0d expected %0d", prod, e_prod); end
        n_compared++;
        if (lat !== e_lat) begin n_mismatched++; $display("[TB] FAIL abort_next_latency: got %0d expected %0d", lat, e_lat); end
    endtask

    task automatic test_latency_cases();
        logic [3:0] av_tab [4] = '{4'd13, 4'd7, 4'd11, 4'd2};
        logic [3:0] bv_tab [4] = '{4'd1, 4'd0, 4'd8, 4'd4};
        logic [7:0] prod, e_prod;
        int lat, e_lat;
        logic done_after;
        for (int i = 0; i < 4; i++) begin
            drive_op(av_tab[i], bv_tab[i], 1'b1, prod, lat, done_after, e_prod, e_lat);
            n_compared++;
            if (prod !== e_prod) begin n_mismatched++; $display("[TB] FAIL case_product a=%0d b=%0d: got %0d expected %0d", av_tab[i], bv_tab[i], prod, e_prod); end
            n_compared++;
            if (lat !== e_lat) begin n_mismatched++; $display("[TB] FAIL case_latency a=%0d b=%0d: got %0d expected %0d", av_tab[i], bv_tab[i], lat, e_lat); end
        end
    endtask

    task automatic test_sweep();
        logic [7:0] prod, e_prod;
        int lat, e_lat;
        logic done_after;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                drive_op(4'(ai), 4'(bi), 1'b0, prod, lat, done_after, e_prod, e_lat);
                n_compared++;
                if (prod !== e_prod) begin n_mismatched++; $display("[TB] FAIL sweep_product a=%0d b=%0d: got %0d expected %0d", ai, bi, prod, e_prod); end
                n_compared++;
                if (lat !== e_lat) begin n_mismatched++; $display("[TB] FAIL sweep_latency a=%0d b=%0d: got %0d expected %0d", ai, bi, lat, e_lat); end
                n_compared++;
                if (done_after !== 1'b0) begin n_mismatched++; $display("[TB] FAIL sweep_done_width a=%0d b=%0d: done still %b", ai, bi, done_after); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_max_operands();
        test_product_hold();
        test_start_held();
        test_reset_mid_calc();
        test_latency_cases();
        test_sweep();
        n_compared++;
        if (sb.size() !== 0) begin n_mismatched++; $display("[TB] FAIL scoreboard_drain: %0d left expected 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d mismatched so far", n_mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
